// File: rtl/keypad_time_entry.sv
// Keypad time/alarm entry: debounces scanner presses and assembles a 4-digit BCD
// 12-hour value, committing it to the clock or alarm on a repeat of the mode key.
module keypad_time_entry #(
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned TIMEOUT  = 2560
) (
   input  logic        clk_256Hz,
   input  logic        reset,
   input  logic [3:0]  key_code,
   input  logic        key_held,
   output logic [15:0] set_value,
   output logic        set_pm,
   output logic        entry_active,
   output logic        entry_target,
   output logic [2:0]  entry_count,
   output logic        load_time,
   output logic        load_alarm,
   output logic        entry_error
);

   localparam int unsigned TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [3:0] KEY_AMPM      = 4'hA;
   localparam logic [3:0] KEY_SET_TIME  = 4'hB;
   localparam logic [3:0] KEY_SET_ALARM = 4'hC;

   typedef enum logic {IDLE, ENTRY} state_t;

   state_t          state;
   logic [3:0]      db_cnt;
   logic            armed;
   logic [TW-1:0]   tmo_cnt;
   logic            db_match;
   logic            key_accept;
   logic            is_mode;
   logic            mode_tgt;
   logic            commit_ok;

   always_comb begin
      db_match   = armed ? key_held : ~key_held;
      key_accept = armed && key_held && (db_cnt == DB_LAST);
      is_mode    = (key_code == KEY_SET_TIME) || (key_code == KEY_SET_ALARM);
      mode_tgt   = (key_code == KEY_SET_ALARM);
      // hour 01..12 from {H1,H0}, minute tens 0..5
      commit_ok  = (entry_count == 3'd4) &&
                   (((set_value[15:12] == 4'd0) && (set_value[11:8] != 4'd0)) ||
                    ((set_value[15:12] == 4'd1) && (set_value[11:8] <= 4'd2))) &&
                   (set_value[7:4] <= 4'd5);
   end

   // One counter serves both directions: highs while armed, lows while disarmed.
   always_ff @(posedge clk_256Hz or posedge reset) begin
      if (reset) begin
         db_cnt <= '0;
         armed  <= 1'b1;
      end else if (db_match) begin
         if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            armed  <= ~armed;
         end else begin
            db_cnt <= db_cnt + 4'd1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

   always_ff @(posedge clk_256Hz or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         set_value    <= '0;
         set_pm       <= 1'b0;
         entry_target <= 1'b0;
         entry_count  <= '0;
         tmo_cnt      <= '0;
         load_time    <= 1'b0;
         load_alarm   <= 1'b0;
         entry_error  <= 1'b0;
      end else begin
         load_time   <= 1'b0;
         load_alarm  <= 1'b0;
         entry_error <= 1'b0;
         case (state)
            IDLE: begin
               if (key_accept && is_mode) begin
                  state        <= ENTRY;
                  entry_target <= mode_tgt;
                  set_value    <= '0;
                  set_pm       <= 1'b0;
                  entry_count  <= '0;
                  tmo_cnt      <= '0;
               end
            end
            ENTRY: begin
               if (key_accept) begin
                  tmo_cnt <= '0;
                  if (key_code <= 4'd9) begin
                     if (entry_count != 3'd4) begin
                        set_value   <= {set_value[11:0], key_code};
                        entry_count <= entry_count + 3'd1;
                     end
                  end else if (key_code == KEY_AMPM) begin
                     set_pm <= ~set_pm;
                  end else if (is_mode) begin
                     if (mode_tgt == entry_target) begin
                        state <= IDLE;
                        if (commit_ok) begin
                           load_time  <= ~entry_target;
                           load_alarm <= entry_target;
                        end else begin
                           entry_error <= 1'b1;
                        end
                     end else begin
                        entry_target <= mode_tgt;
                        set_value    <= '0;
                        set_pm       <= 1'b0;
                        entry_count  <= '0;
                     end
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state       <= IDLE;
                  entry_error <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign entry_active = (state == ENTRY);

endmodule
